button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Conditions the raw active-low pushbuttons (Run, Continue, ...) before they reach the SLC-3 top.
//  Per button: 2-flop synchronizer, counter debounce, one-cycle press/release pulses.
//  Also raises all_held once every button has been held long enough; the top uses it as the
//  Run+Continue combination reset. Sits directly upstream of the SLC-3 top level.
// PARAMETERS
//  NUM_BTN          2       number of buttons handled (independent lanes)
//  DEBOUNCE_CYCLES  50000   consecutive differing samples needed to accept a change (>=1; 1 ms @ 50 MHz)
//  HOLD_CYCLES      1000    cycles all buttons must be debounced-pressed before all_held (>=1)
// PORTS
//  Clk          in   1        system clock, all state on rising edge
//  Reset_n      in   1        asynchronous, active-low reset
//  btn_n_in     in   NUM_BTN  raw key pins, 0 = pressed, asynchronous to Clk
//  btn_level    out  NUM_BTN  debounced state, 1 = pressed
//  btn_press    out  NUM_BTN  1-cycle pulse when btn_level rises
//  btn_release  out  NUM_BTN  1-cycle pulse when btn_level falls
//  all_held     out  1        1 while every btn_level has been 1 for >= HOLD_CYCLES cycles
// BEHAVIOUR
//  Reset (Reset_n=0, async, any time incl. mid-debounce):
//  - sync flops = 1 (released); debounce/hold counters = 0.
//  - btn_level, btn_press, btn_release, all_held = 0 immediately; held until Reset_n=1.
//  Synchronizer: ff1 <= btn_n_in, ff2 <= ff1; raw_s = ~ff2 (active-high).
//  Debounce, per lane, each edge:
//  - raw_s == btn_level: counter <= 0.
//  - raw_s != btn_level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
//  - raw_s != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level <= raw_s, counter <= 0.
//  - Any glitch back to btn_level before acceptance clears the counter; no partial credit.
//  - Counter width = $clog2(DEBOUNCE_CYCLES+1); never wraps.
//  Latency: pin steady from before edge k -> ff2 updated at edge k+1 -> btn_level changes at edge
//  k+1+DEBOUNCE_CYCLES. Edge k+1+DEBOUNCE_CYCLES is DEBOUNCE_CYCLES+2 edges including edge k.
//  Pulses, registered:
//  - btn_press/btn_release go high on the same edge btn_level changes and low on the next edge.
//  - Never both high in one lane; lanes independent, so simultaneous pulses on several lanes are legal.
//  Hold counter:
//  - While &btn_level: increment, saturating at HOLD_CYCLES.
//  - When any btn_level = 0: cleared to 0 on that edge.
//  - all_held = (hold counter == HOLD_CYCLES), registered: rises HOLD_CYCLES edges after the edge
//    on which the last btn_level rose.
//  - all_held falls on the same edge any btn_level falls.
//  Button already pressed when Reset_n deasserts: treated as a new press; btn_press fires after the
//  normal latency (DEBOUNCE_CYCLES+2 edges).
//  No other state; no FSM beyond per-lane stable bit + counters.
// TESTING (bench uses NUM_BTN=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
//  1 Reset_n=0, btn_n_in=2'b00 for 20 cycles -> all outputs 0 throughout, no pulses.
//  2 Press lane 0 cleanly from edge k -> btn_level[0]=1 after edge k+5; btn_press[0] high exactly one
//    cycle; lane 1 and btn_release stay 0.
//  3 Lane 0 low 3 cycles then high -> no level change, no pulses.
//    Lane 0 low 4+ cycles -> btn_press[0] after edge k+5.
//  4 Release lane 0 with bounce (toggle every 2 cycles for 10 cycles), then steady high ->
//    exactly one btn_release[0], 6 edges after the final transition.
//  5 Both buttons pressed and held -> all_held rises 8 edges after second btn_level rises.
//    Release lane 1 -> all_held falls on the edge btn_level[1] falls.
//  6 Hold lane 1; assert Reset_n mid-operation -> outputs 0 asynchronously.
//    Deassert Reset_n -> single btn_press[1] after 6 edges.

Source files
------------

// File: rtl/button_conditioner.sv
// Conditions raw active-low pushbuttons: 2-flop synchronizer, counter debounce,
// one-cycle press/release pulses and an all-buttons-held indication.
module button_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 1000
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NUM_BTN-1:0] btn_n_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               all_held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic [NUM_BTN-1:0] sync_ff1;
  logic [NUM_BTN-1:0] sync_ff2;
  logic [NUM_BTN-1:0] raw_s;
  logic [NUM_BTN-1:0] level_next;
  logic [CW-1:0]      db_cnt      [NUM_BTN];
  logic [CW-1:0]      db_cnt_next [NUM_BTN];
  logic [HW-1:0]      hold_cnt;
  logic [HW-1:0]      hold_next;

  assign raw_s = ~sync_ff2;

  // A lane only accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    level_next = btn_level;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_next[i] = '0;
      if (raw_s[i] != btn_level[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          level_next[i] = raw_s[i];
        end else begin
          db_cnt_next[i] = db_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    hold_next = '0;
    if (&btn_level) begin
      hold_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);
    end
  end

  // all_held looks at the next levels so it drops on the same edge any button is released.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_ff1    <= '1;
      sync_ff2    <= '1;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      hold_cnt    <= '0;
      all_held    <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_ff1    <= btn_n_in;
      sync_ff2    <= sync_ff1;
      btn_level   <= level_next;
      btn_press   <= level_next & ~btn_level;
      btn_release <= ~level_next & btn_level;
      hold_cnt    <= hold_next;
      all_held    <= (&level_next) && (hold_next == HOLD_MAX);
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= db_cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// button activity, compared against a sample-history reference model.
module tb_button_conditioner;

  localparam int NB = 2;
  localparam int DC = 4;
  localparam int HC = 8;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [NB-1:0] btn_n_in = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          all_held;

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HC)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .btn_n_in(btn_n_in),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .all_held(all_held)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int step_no = 0;
  int press_cnt [NB];
  int release_cnt [NB];
  int last_press_step [NB];
  int last_release_step [NB];
  int held_rise_step = -1;
  int held_fall_step = -1;
  logic prev_held = 1'b0;

  // Reference model: a level flips once the last DC synchronized samples all disagree with it.
  logic [NB-1:0] pin_q [$];
  bit            hist [NB][$];
  logic [NB-1:0] m_level, m_press, m_release, m_new, m_raw;
  logic          m_held;
  int            consec;
  bit            all_diff;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pin_q.delete();
      pin_q.push_back('1);
      pin_q.push_back('1);
      for (int l = 0; l < NB; l++) hist[l].delete();
      m_level = '0; m_press = '0; m_release = '0; m_held = 1'b0; consec = 0;
    end else begin
      m_raw = ~pin_q.pop_front();
      pin_q.push_back(btn_n_in);
      m_new = m_level;
      for (int l = 0; l < NB; l++) begin
        hist[l].push_back(m_raw[l]);
        if (hist[l].size() > DC) void'(hist[l].pop_front());
        if (hist[l].size() == DC) begin
          all_diff = 1'b1;
          for (int j = 0; j < DC; j++) if (hist[l][j] == m_level[l]) all_diff = 1'b0;
          if (all_diff) begin
            m_new[l] = m_raw[l];
            hist[l].delete();
          end
        end
      end
      m_press   = m_new & ~m_level;
      m_release = ~m_new & m_level;
      m_level   = m_new;
      if (&m_level) consec = (consec > HC) ? consec : consec + 1;
      else consec = 0;
      m_held = (consec >= HC + 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_stats();
    for (int l = 0; l < NB; l++) begin
      press_cnt[l] = 0; release_cnt[l] = 0;
      last_press_step[l] = -1; last_release_step[l] = -1;
    end
    held_rise_step = -1;
    held_fall_step = -1;
  endtask

  task automatic step(input logic [NB-1:0] pins);
    btn_n_in = pins;
    @(posedge Clk);
    @(negedge Clk);
    step_no++;
    check("level", 32'(btn_level), 32'(m_level));
    check("press", 32'(btn_press), 32'(m_press));
    check("release", 32'(btn_release), 32'(m_release));
    check("all_held", 32'(all_held), 32'(m_held));
    for (int l = 0; l < NB; l++) begin
      if (btn_press[l]) begin press_cnt[l]++; last_press_step[l] = step_no; end
      if (btn_release[l]) begin release_cnt[l]++; last_release_step[l] = step_no; end
    end
    if (all_held && !prev_held) held_rise_step = step_no;
    if (!all_held && prev_held) held_fall_step = step_no;
    prev_held = all_held;
  endtask

  int k;
  int dur;
  logic [NB-1:0] pins;

  initial begin
    clear_stats();

    // Held in reset with both buttons down: nothing may come out.
    Reset_n = 1'b0;
    repeat (20) step(2'b00);
    check("rst_pulses", 32'(press_cnt[0] + press_cnt[1] + release_cnt[0] + release_cnt[1]), 0);
    check("rst_level", 32'(btn_level), 0);
    repeat (2) step(2'b11);
    Reset_n = 1'b1;
    repeat (4) step(2'b11);

    // Clean press of lane 0.
    clear_stats();
    k = step_no + 1;
    repeat (5) step(2'b10);
    check("lvl0_before", 32'(btn_level[0]), 0);
    step(2'b10);
    check("lvl0_after", 32'(btn_level[0]), 1);
    check("press0_step", 32'(last_press_step[0]), 32'(k + 5));
    repeat (4) step(2'b10);
    check("press0_cnt", 32'(press_cnt[0]), 1);
    check("press1_cnt", 32'(press_cnt[1]), 0);
    check("no_release", 32'(release_cnt[0] + release_cnt[1]), 0);

    // Short press is rejected, a long one accepted.
    repeat (8) step(2'b11);
    clear_stats();
    repeat (3) step(2'b10);
    repeat (8) step(2'b11);
    check("short_press_cnt", 32'(press_cnt[0]), 0);
    check("short_level", 32'(btn_level[0]), 0);
    k = step_no + 1;
    repeat (6) step(2'b10);
    check("long_press_step", 32'(last_press_step[0]), 32'(k + 5));
    check("long_press_cnt", 32'(press_cnt[0]), 1);

    // Bouncy release of lane 0.
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      if (i == 8) k = step_no + 1;
      step({1'b1, ((i / 2) % 2 == 0) ? 1'b1 : 1'b0});
    end
    repeat (8) step(2'b11);
    check("bounce_rel_cnt", 32'(release_cnt[0]), 1);
    check("bounce_rel_step", 32'(last_release_step[0]), 32'(k + 5));

    // Both held, then lane 1 released.
    clear_stats();
    repeat (3) step(2'b10);
    k = step_no + 1;
    repeat (16) step(2'b00);
    check("held_rise_step", 32'(held_rise_step), 32'(k + 13));
    check("held_high", 32'(all_held), 1);
    k = step_no + 1;
    repeat (6) step(2'b10);
    check("held_fall_step", 32'(held_fall_step), 32'(k + 5));
    check("rel1_step", 32'(last_release_step[1]), 32'(k + 5));

    // Asynchronous reset while lane 1 is held, then re-press after release of reset.
    repeat (8) step(2'b11);
    repeat (8) step(2'b01);
    check("lane1_held", 32'(btn_level[1]), 1);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst", 32'({btn_level, btn_press, btn_release, all_held}), 0);
    repeat (3) step(2'b01);
    clear_stats();
    Reset_n = 1'b1;
    k = step_no + 1;
    repeat (10) step(2'b01);
    check("post_rst_press_cnt", 32'(press_cnt[1]), 1);
    check("post_rst_press_step", 32'(last_press_step[1]), 32'(k + 5));

    // Random button activity with occasional resets.
    repeat (80) begin
      pins = NB'($urandom_range(0, 3));
      dur = $urandom_range(1, 12);
      repeat (dur) step(pins);
      if ($urandom_range(0, 19) == 0) begin
        Reset_n = 1'b0;
        step(pins);
        Reset_n = 1'b1;
      end
    end
    repeat (20) step(2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
